// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Constants and types shared by the TMDS encoder/decoder pair.
//   - TOKEN_Cxx    : the four 10-bit control tokens, indexed by {c1,c0}
//   - align_state_t: word-aligner state (HUNT / LOCKED)
//   - next_offset(): slip-offset increment that wraps 9 -> 0
// -----------------------------------------------------------------------------
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_t;

  // A 10-bit word has ten possible bit alignments, so the offset wraps at 9.
  function automatic logic [3:0] next_offset(input logic [3:0] offset);
    return (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// -----------------------------------------------------------------------------
// tmds_symbol_decode
// Purely combinational decode of one aligned 10-bit TMDS symbol.
// Ports:
//   q        in  [9:0] aligned symbol, bit 0 first on the wire
//   data     out [7:0] decoded pixel byte (meaningful when is_token = 0)
//   control  out [1:0] {c1,c0} of a control token (meaningful when is_token = 1)
//   is_token out       q is one of the four control tokens
// -----------------------------------------------------------------------------
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] q,
  output logic [7:0] data,
  output logic [1:0] control,
  output logic       is_token
);

  // q[9] flags that the transmitter inverted the payload for DC balance.
  logic [7:0] d;
  assign d = q[9] ? ~q[7:0] : q[7:0];

  // q[8] selects whether the transmitter chained bits with XOR (1) or XNOR (0).
  assign data[0] = d[0];
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_unchain
      assign data[gi] = q[8] ? (d[gi] ^ d[gi-1]) : ~(d[gi] ^ d[gi-1]);
    end
  endgenerate

  always_comb begin
    control  = 2'b00;
    is_token = 1'b1;
    case (q)
      TOKEN_C00: control = 2'b00;
      TOKEN_C01: control = 2'b01;
      TOKEN_C10: control = 2'b10;
      TOKEN_C11: control = 2'b11;
      default:   is_token = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
// Word aligner plus TMDS symbol decoder for one channel. Finds the 10-bit
// symbol boundary by hunting for control tokens, slipping one bit whenever
// too many non-token words are seen, and decodes pixel/control symbols once
// locked.
// Ports:
//   clk_in        pixel clock (only clock)
//   rst_in        synchronous active-low reset
//   raw_in        unaligned 10-bit word from the deserializer, bit 0 first
//   raw_valid_in  raw_in valid this cycle
//   data_out      decoded pixel byte (held across control tokens)
//   control_out   decoded {c1,c0} (held across data words)
//   ve_out        1 = video data, 0 = control token
//   valid_out     outputs valid; only for words decoded while LOCKED
//   locked_out    aligner is LOCKED
//   offset_out    current bit-slip offset, 0..9
//   err_count_out number of LOCKED->HUNT drops, saturating
// Build option: define TMDS_DECODER_ERR_CNT_EN to build the drop counter;
// otherwise err_count_out is tied to zero.
// Latency: 2 cycles from raw_valid_in to valid_out. Stage 1 registers the
// decoded window and the aligner state update, stage 2 the output fields.
// -----------------------------------------------------------------------------
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS = 8,
  parameter int MISS_LIMIT  = 16,
  parameter int LOSS_LIMIT  = 2048
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  raw_in,
  input  logic        raw_valid_in,
  output logic [7:0]  data_out,
  output logic [1:0]  control_out,
  output logic        ve_out,
  output logic        valid_out,
  output logic        locked_out,
  output logic [3:0]  offset_out,
  output logic [15:0] err_count_out
);

  localparam int MATCH_W = $clog2(LOCK_TOKENS + 1);
  localparam int MISS_W  = $clog2(MISS_LIMIT + 1);
  localparam int GAP_W   = $clog2(LOSS_LIMIT + 1);

  // Counter values on which the current word completes the respective limit.
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_TOKENS - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_LIMIT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(LOSS_LIMIT - 1);

  align_state_t       state_reg;
  logic [9:0]         prev_word_reg;
  logic [3:0]         offset_reg;
  logic [MATCH_W-1:0] match_cnt_reg;
  logic [MISS_W-1:0]  miss_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;

  logic               s1_valid_reg;
  logic               s1_emit_reg;
  logic               s1_token_reg;
  logic [7:0]         s1_data_reg;
  logic [1:0]         s1_control_reg;

  logic [7:0]         data_reg;
  logic [1:0]         control_reg;
  logic               ve_reg;
  logic               valid_reg;

  // The symbol may straddle the previous and current raw words.
  logic [19:0] pair;
  logic [9:0]  window;
  assign pair   = {raw_in, prev_word_reg};
  assign window = 10'(pair >> offset_reg);

  logic [7:0] sym_data;
  logic [1:0] sym_control;
  logic       sym_is_token;

  tmds_symbol_decode u_symbol_decode (
    .q        (window),
    .data     (sym_data),
    .control  (sym_control),
    .is_token (sym_is_token)
  );

  logic lock_event;
  logic slip_event;
  logic loss_event;
  assign lock_event = (state_reg == ST_HUNT)   &&  sym_is_token && (match_cnt_reg == MATCH_LAST);
  assign slip_event = (state_reg == ST_HUNT)   && !sym_is_token && (miss_cnt_reg  == MISS_LAST);
  assign loss_event = (state_reg == ST_LOCKED) && !sym_is_token && (gap_cnt_reg   == GAP_LAST);

  // Aligner FSM and stage-1 register; everything holds on invalid cycles
  // except the stage valid flag.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg      <= ST_HUNT;
      prev_word_reg  <= '0;
      offset_reg     <= '0;
      match_cnt_reg  <= '0;
      miss_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      s1_valid_reg   <= 1'b0;
      s1_emit_reg    <= 1'b0;
      s1_token_reg   <= 1'b0;
      s1_data_reg    <= '0;
      s1_control_reg <= '0;
    end else begin
      s1_valid_reg <= raw_valid_in;
      if (raw_valid_in) begin
        prev_word_reg  <= raw_in;
        // The token that completes the lock count is itself emitted.
        s1_emit_reg    <= (state_reg == ST_LOCKED) || lock_event;
        s1_token_reg   <= sym_is_token;
        s1_data_reg    <= sym_data;
        s1_control_reg <= sym_control;
        case (state_reg)
          ST_HUNT: begin
            if (sym_is_token) begin
              miss_cnt_reg <= '0;
              if (lock_event) begin
                state_reg     <= ST_LOCKED;
                match_cnt_reg <= '0;
                gap_cnt_reg   <= '0;
              end else begin
                match_cnt_reg <= match_cnt_reg + MATCH_W'(1);
              end
            end else begin
              match_cnt_reg <= '0;
              if (slip_event) begin
                offset_reg   <= next_offset(offset_reg);
                miss_cnt_reg <= '0;
              end else begin
                miss_cnt_reg <= miss_cnt_reg + MISS_W'(1);
              end
            end
          end
          ST_LOCKED: begin
            if (sym_is_token) begin
              gap_cnt_reg <= '0;
            end else if (loss_event) begin
              // Offset is kept: the link most likely glitched rather than moved.
              state_reg     <= ST_HUNT;
              match_cnt_reg <= '0;
              miss_cnt_reg  <= '0;
              gap_cnt_reg   <= '0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
          end
          default: state_reg <= ST_HUNT;
        endcase
      end
    end
  end

  // Output stage: data and control each hold while the other kind arrives.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      data_reg    <= '0;
      control_reg <= '0;
      ve_reg      <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= s1_valid_reg && s1_emit_reg;
      if (s1_valid_reg) begin
        if (s1_token_reg) begin
          control_reg <= s1_control_reg;
          ve_reg      <= 1'b0;
        end else begin
          data_reg <= s1_data_reg;
          ve_reg   <= 1'b1;
        end
      end
    end
  end

  assign data_out    = data_reg;
  assign control_out = control_reg;
  assign ve_out      = ve_reg;
  assign valid_out   = valid_reg;
  assign locked_out  = (state_reg == ST_LOCKED);
  assign offset_out  = offset_reg;

`ifdef TMDS_DECODER_ERR_CNT_EN
  logic [15:0] err_count_reg;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      err_count_reg <= '0;
    end else if (raw_valid_in && loss_event && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign err_count_out = err_count_reg;
`else
  assign err_count_out = 16'd0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;

  localparam int LOCK_TOKENS = 8;
  localparam int MISS_LIMIT  = 16;
  localparam int LOSS_LIMIT  = 2048;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [9:0]  raw_in = '0;
  logic        raw_valid_in = 1'b0;
  logic [7:0]  data_out;
  logic [1:0]  control_out;
  logic        ve_out;
  logic        valid_out;
  logic        locked_out;
  logic [3:0]  offset_out;
  logic [15:0] err_count_out;

  tmds_decoder #(
    .LOCK_TOKENS (LOCK_TOKENS),
    .MISS_LIMIT  (MISS_LIMIT),
    .LOSS_LIMIT  (LOSS_LIMIT)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .raw_in        (raw_in),
    .raw_valid_in  (raw_valid_in),
    .data_out      (data_out),
    .control_out   (control_out),
    .ve_out        (ve_out),
    .valid_out     (valid_out),
    .locked_out    (locked_out),
    .offset_out    (offset_out),
    .err_count_out (err_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int a5_seen = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       ve;
    int         due;
  } exp_t;
  exp_t sb[$];

  // ---------------- reference model (symbol-level) ----------------
  logic [9:0] m_prev;
  int         m_off, m_match, m_miss, m_gap, m_err;
  bit         m_locked;
  logic [7:0] m_last_data;
  logic [1:0] m_last_ctrl;

  function automatic bit ref_token(input logic [9:0] w, output logic [1:0] c);
    c = 2'b00;
    if (w == 10'b1101010100) begin c = 2'b00; return 1; end
    if (w == 10'b0010101011) begin c = 2'b01; return 1; end
    if (w == 10'b0101010100) begin c = 2'b10; return 1; end
    if (w == 10'b1010101011) begin c = 2'b11; return 1; end
    return 0;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d, o;
    d = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~w[8];
    return o;
  endfunction

  function automatic logic [9:0] ref_window(input logic [9:0] r);
    logic [19:0] pair;
    pair = {r, m_prev};
    return 10'((pair >> m_off) & 20'h3FF);
  endfunction

  // Standard TMDS transition-minimising stage plus optional inversion.
  function automatic logic [9:0] enc(input logic [7:0] d, input bit inv);
    logic [8:0] qm;
    int n1;
    bit use_xnor;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  task automatic model_reset();
    m_prev = '0; m_off = 0; m_match = 0; m_miss = 0; m_gap = 0; m_err = 0;
    m_locked = 0; m_last_data = '0; m_last_ctrl = '0;
  endtask

  task automatic model_step(input logic [9:0] r, input int due);
    logic [9:0] w;
    logic [1:0] c;
    bit tok, emit;
    exp_t e;
    w = ref_window(r);
    m_prev = r;
    tok = ref_token(w, c);
    emit = 0;
    if (!m_locked) begin
      if (tok) begin
        m_miss = 0;
        m_match++;
        if (m_match == LOCK_TOKENS) begin
          m_locked = 1; emit = 1; m_match = 0; m_gap = 0;
        end
      end else begin
        m_match = 0;
        m_miss++;
        if (m_miss == MISS_LIMIT) begin
          m_off = (m_off + 1) % 10;
          m_miss = 0;
        end
      end
    end else begin
      emit = 1;
      if (tok) m_gap = 0;
      else begin
        m_gap++;
        if (m_gap == LOSS_LIMIT) begin
          m_locked = 0; m_match = 0; m_miss = 0; m_gap = 0;
          if (m_err < 65535) m_err++;
        end
      end
    end
    if (tok) m_last_ctrl = c;
    else     m_last_data = ref_decode(w);
    if (emit) begin
      e.data = m_last_data; e.ctrl = m_last_ctrl; e.ve = !tok; e.due = due;
      sb.push_back(e);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid word.
  always @(negedge clk_in) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missing_output: no valid_out at cycle %0d, expected data %0h ctrl %0h", e.due, e.data, e.ctrl);
    end
    if (valid_out === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: valid_out=1 at cycle %0d with nothing expected", cyc);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.data || control_out !== e.ctrl || ve_out !== e.ve || cyc != e.due) begin
          errors++;
          $display("FAIL output_word: got data %0h ctrl %0h ve %0b cycle %0d, expected data %0h ctrl %0h ve %0b cycle %0d",
                   data_out, control_out, ve_out, cyc, e.data, e.ctrl, e.ve, e.due);
        end
        if (ve_out === 1'b1 && data_out === 8'hA5) a5_seen++;
      end
    end
  end

  // Drive one word; the DUT state visible now must match the model before
  // this word is applied.
  task automatic send(input logic [9:0] r, input logic v);
    @(posedge clk_in); #1;
    chk("locked_track", 32'(locked_out), 32'(m_locked));
    chk("offset_track", 32'(offset_out), 32'(m_off));
    raw_in = r;
    raw_valid_in = v;
    if (v) model_step(r, cyc + 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(10'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    raw_valid_in = 1'b0;
    @(posedge clk_in); #1;
    sb.delete();
    model_reset();
    @(negedge clk_in);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_control", 32'(control_out), 0);
    chk("rst_ve", 32'(ve_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_locked", 32'(locked_out), 0);
    chk("rst_offset", 32'(offset_out), 0);
    chk("rst_err", 32'(err_count_out), 0);
    rst_in = 1'b1;
  endtask

  function automatic logic [9:0] random_token();
    logic [9:0] t [4];
    t[0] = 10'b1101010100; t[1] = 10'b0010101011;
    t[2] = 10'b0101010100; t[3] = 10'b1010101011;
    return t[$urandom_range(0, 3)];
  endfunction

  // Token stream whose symbol boundaries sit 3 bits into the raw words.
  function automatic logic rot_bit(input int p);
    logic [9:0] t;
    t = 10'b1101010100;
    if (p < 3) return 1'b0;
    return t[(p - 3) % 10];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] r;
    logic [1:0] c;
    int off_seq[$];
    int last_off;

    model_reset();
    repeat (3) @(posedge clk_in);
    do_reset();

    // Blanking of 00 tokens at offset 0.
    for (int i = 0; i < 20; i++) send(10'b1101010100, 1'b1);
    idle(3);
    chk("lock_tokens_locked", 32'(locked_out), 1);
    chk("lock_tokens_offset", 32'(offset_out), 0);
    chk("lock_tokens_ctrl", 32'(control_out), 0);
    chk("lock_tokens_ve", 32'(ve_out), 0);

    // Encoded 0xA5 pixels framed by tokens.
    do_reset();
    a5_seen = 0;
    for (int i = 0; i < 12; i++) send(10'b1101010100, 1'b1);
    for (int i = 0; i < 20; i++) send(enc(8'hA5, i[0]), 1'b1);
    for (int i = 0; i < 4; i++) send(10'b0010101011, 1'b1);
    idle(3);
    chk("a5_count", 32'(a5_seen), 20);
    chk("a5_last_data", 32'(data_out), 32'h A5);

    // Rotated blanking: aligner must slip to offset 3.
    do_reset();
    last_off = 0;
    off_seq.push_back(0);
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 10; b++) r[b] = rot_bit(10 * n + b);
      send(r, 1'b1);
      if (int'(offset_out) != last_off) begin
        last_off = int'(offset_out);
        off_seq.push_back(last_off);
      end
    end
    idle(3);
    chk("slip_steps", 32'(off_seq.size()), 4);
    for (int i = 0; i < off_seq.size() && i < 4; i++) chk("slip_step_value", 32'(off_seq[i]), 32'(i));
    chk("slip_locked", 32'(locked_out), 1);
    chk("slip_offset", 32'(offset_out), 3);

    // Loss of lock after LOSS_LIMIT consecutive data words.
    for (int i = 0; i < LOSS_LIMIT; i++) begin
      do r = 10'($urandom); while (ref_token(ref_window(r), c));
      send(r, 1'b1);
    end
    send(10'h000, 1'b0);
    chk("loss_locked", 32'(locked_out), 0);
    send(10'h000, 1'b0);
    chk("loss_offset_kept", 32'(offset_out), 3);
`ifdef TMDS_DECODER_ERR_CNT_EN
    chk("loss_err_count", 32'(err_count_out), 1);
`else
    chk("loss_err_count", 32'(err_count_out), 0);
`endif
    idle(2);

    // Gapped input while locked.
    do_reset();
    for (int i = 0; i < 12; i++) send(random_token(), 1'b1);
    for (int i = 0; i < 300; i++) begin
      send(($urandom_range(0, 3) == 0) ? random_token() : 10'($urandom), 1'b1);
      send(10'($urandom), 1'b0);
    end
    idle(3);
    chk("gapped_locked", 32'(locked_out), 1);

    // Mid-stream reset: pipeline contents must be discarded.
    for (int i = 0; i < 10; i++) send(10'($urandom), 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) send(10'b1101010100, 1'b1);
    idle(4);
    chk("post_reset_locked", 32'(locked_out), 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
